ifetch_unit: RTL and testbench

Instruction fetch stage feeding the single-cycle decode/control path. Holds the PC, issues word fetches to instruction memory over a request/grant/response handshake, buffers returned instructions in a small FIFO, and presents the head instruction with its decoded `op`/`funct3`/`funct7b5` fields to the controller. Consumes the controller's `PCSrc` as a redirect, flushing buffered and in-flight fetches.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/ifetch_fifo.sv | 58 +++++
 rtl/ifetch_unit.sv | 138 +++++++++++++
 tb/tb_ifetch_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: NOP encoding, base opcodes,
// fetch FSM state type and the buffered fetch entry layout.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_REG    = 7'h33;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_JAL    = 7'h6f;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2
   } ifetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with flush; head entry is read straight from the
// storage registers, so a push becomes visible the following cycle.
module ifetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic [W-1:0]               din,
   input  logic                       pop,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          wr;
   logic          rd;

   assign full  = (count == DEPTH_CNT);
   assign empty = (count == '0);
   assign rd    = pop & ~empty;
   assign wr    = push & (~full | rd);
   assign dout  = mem[rptr];

   always_ff @(posedge clk) begin
      if (wr && !flush) mem[wptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr) wptr <= wptr + 1'b1;
         if (rd) rptr <= rptr + 1'b1;
         case ({wr, rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, instruction
// buffer and decode-field split. `IFETCH_BYPASS_EN enables zero-latency bypass.
module ifetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pcplus4,
   output logic [6:0]  op,
   output logic [2:0]  funct3,
   output logic        funct7b5
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

   ifetch_state_t state;
   logic [31:0]   pc;
   logic [31:0]   fetch_pc;
   logic [31:0]   target;
   logic          granted;
   logic          push;
   logic          pop;
   logic          bypass;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;
   fetch_entry_t  head;
   fetch_entry_t  entry_in;
   logic          unused_bits;

   assign target      = {redirect_pc[31:2], 2'b00};
   assign unused_bits = ^redirect_pc[1:0];

   // rst_n gates the request so nothing is issued while reset is held
   assign imem_req  = rst_n && (state == S_REQ) && (fifo_count < DEPTH_CNT);
   assign imem_addr = pc;
   assign granted   = imem_req & imem_gnt;

`ifdef IFETCH_BYPASS_EN
   assign bypass = (state == S_WAIT) && imem_rvalid && !redirect && fifo_empty;
`else
   assign bypass = 1'b0;
`endif

   assign push = (state == S_WAIT) && imem_rvalid && !redirect && !fifo_full
                 && !(bypass && id_ready);
   assign pop  = !fifo_empty && id_ready;

   assign entry_in.pc    = fetch_pc;
   assign entry_in.instr = imem_rdata;

   ifetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (64)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect),
      .push  (push),
      .din   (entry_in),
      .pop   (pop),
      .dout  (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_REQ;
         pc       <= RESET_PC;
         fetch_pc <= RESET_PC;
      end else begin
         unique case (state)
            S_REQ: begin
               if (redirect) begin
                  pc    <= target;
                  state <= granted ? S_DRAIN : S_REQ;
               end else if (granted) begin
                  fetch_pc <= pc;
                  pc       <= pc + 32'd4;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (redirect) begin
                  pc    <= target;
                  state <= imem_rvalid ? S_REQ : S_DRAIN;
               end else if (imem_rvalid) begin
                  state <= S_REQ;
               end
            end
            S_DRAIN: begin
               if (redirect) pc <= target;
               if (imem_rvalid) state <= S_REQ;
            end
            default: state <= S_REQ;
         endcase
      end
   end

   // With an empty buffer the stage shows a NOP tagged with the current fetch PC
   always_comb begin
      id_valid = !fifo_empty;
      id_instr = head.instr;
      id_pc    = head.pc;
      if (fifo_empty) begin
         id_instr = NOP_INSTR;
         id_pc    = pc;
      end
      if (bypass) begin
         id_valid = 1'b1;
         id_instr = imem_rdata;
         id_pc    = fetch_pc;
      end
   end

   assign id_pcplus4 = id_pc + 32'd4;
   assign op         = id_instr[6:0];
   assign funct3     = id_instr[14:12];
   assign funct7b5   = id_instr[30];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit (default build, FIFO_DEPTH=2): per-cycle vector
// table plus hand sequences for wrap, async reset and back-pressure.
module tb_ifetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pcplus4;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7b5;

   localparam logic [31:0] NOP = 32'h0000_0013;

   int pass_cnt  = 0;
   int total_cnt = 0;

   ifetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_instr    (id_instr),
      .id_pc       (id_pc),
      .id_pcplus4  (id_pcplus4),
      .op          (op),
      .funct3      (funct3),
      .funct7b5    (funct7b5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_vld;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
   } vec_t;

   vec_t tbl [22];

   logic        pend;
   logic [31:0] pend_addr;
   int          grants;

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
   endtask

   task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                        input logic rdy, input logic rr, input logic [31:0] rp);
      @(negedge clk);
      imem_gnt    = g;
      imem_rvalid = rv;
      imem_rdata  = rd;
      id_ready    = rdy;
      redirect    = rr;
      redirect_pc = rp;
      #1;
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a + 32'h00A0_0013;
   endfunction

   // Memory that always grants and answers one cycle after the grant
   task automatic auto_cycle(input logic rdy);
      @(negedge clk);
      imem_gnt    = 1'b1;
      imem_rvalid = pend;
      imem_rdata  = pend ? instr_of(pend_addr) : 32'h0;
      id_ready    = rdy;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      #1;
      if (imem_req) begin
         pend      = 1'b1;
         pend_addr = imem_addr;
         grants++;
      end else begin
         pend = 1'b0;
      end
   endtask

   task automatic chk_reset_outputs(input int idx);
      chk("rst_req",    idx, 32'(imem_req),  32'h0);
      chk("rst_addr",   idx, imem_addr,      32'h0);
      chk("rst_valid",  idx, 32'(id_valid),  32'h0);
      chk("rst_instr",  idx, id_instr,       NOP);
      chk("rst_pc",     idx, id_pc,          32'h0);
      chk("rst_pcplus4",idx, id_pcplus4,     32'h4);
   endtask

   initial begin
      logic [31:0] got_pc [4];
      logic [31:0] got_in [4];
      int          npop;
      logic [31:0] ei;

      //            gnt  rv   rdata          rdy  rr   rpc           req  addr          vld  instr          pc
      tbl[0]  = '{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,       1'b1,32'h0,       1'b0,NOP,          32'h0};
      tbl[1]  = '{1'b0,1'b1,32'h00500093, 1'b0,1'b0,32'h0,       1'b0,32'h4,       1'b0,NOP,          32'h4};
      tbl[2]  = '{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,       1'b1,32'h4,       1'b1,32'h00500093, 32'h0};
      tbl[3]  = '{1'b0,1'b1,32'h00A00113, 1'b1,1'b0,32'h0,       1'b0,32'h8,       1'b1,32'h00500093, 32'h0};
      tbl[4]  = '{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,       1'b1,32'h8,       1'b1,32'h00A00113, 32'h4};
      tbl[5]  = '{1'b0,1'b1,32'h002081B3, 1'b0,1'b0,32'h0,       1'b0,32'hC,       1'b1,32'h00A00113, 32'h4};
      tbl[6]  = '{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,       1'b0,32'hC,       1'b1,32'h00A00113, 32'h4};
      tbl[7]  = '{1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,       1'b0,32'hC,       1'b1,32'h00A00113, 32'h4};
      tbl[8]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,       1'b1,32'hC,       1'b1,32'h002081B3, 32'h8};
      tbl[9]  = '{1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0,       1'b1,32'hC,       1'b1,32'h002081B3, 32'h8};
      tbl[10] = '{1'b0,1'b0,32'h0,        1'b0,1'b1,32'h00000103,1'b0,32'h10,      1'b0,NOP,          32'h10};
      tbl[11] = '{1'b0,1'b1,32'hDEADBEEF, 1'b1,1'b0,32'h0,       1'b0,32'h100,     1'b0,NOP,          32'h100};
      tbl[12] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,       1'b1,32'h100,     1'b0,NOP,          32'h100};
      tbl[13] = '{1'b1,1'b0,32'h0,        1'b0,1'b1,32'h00000200,1'b1,32'h100,     1'b0,NOP,          32'h100};
      tbl[14] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,       1'b0,32'h200,     1'b0,NOP,          32'h200};
      tbl[15] = '{1'b0,1'b1,32'h11111111, 1'b0,1'b0,32'h0,       1'b0,32'h200,     1'b0,NOP,          32'h200};
      tbl[16] = '{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,       1'b1,32'h200,     1'b0,NOP,          32'h200};
      tbl[17] = '{1'b0,1'b1,32'h40208233, 1'b0,1'b0,32'h0,       1'b0,32'h204,     1'b0,NOP,          32'h204};
      tbl[18] = '{1'b0,1'b0,32'h0,        1'b1,1'b0,32'h0,       1'b1,32'h204,     1'b1,32'h40208233, 32'h200};
      tbl[19] = '{1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,       1'b1,32'h204,     1'b0,NOP,          32'h204};
      tbl[20] = '{1'b0,1'b1,32'h22222222, 1'b0,1'b1,32'h00000300,1'b0,32'h208,     1'b0,NOP,          32'h208};
      tbl[21] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,       1'b1,32'h300,     1'b0,NOP,          32'h300};

      rst_n       = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      id_ready    = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      pend        = 1'b0;
      pend_addr   = 32'h0;
      grants      = 0;

      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk_reset_outputs(0);

      @(posedge clk); #2 rst_n = 1'b1;

      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, tbl[i].ready,
               tbl[i].redir, tbl[i].rpc);
         ei = tbl[i].e_instr;
         chk("req",      i, 32'(imem_req),  32'(tbl[i].e_req));
         chk("addr",     i, imem_addr,      tbl[i].e_addr);
         chk("valid",    i, 32'(id_valid),  32'(tbl[i].e_vld));
         chk("instr",    i, id_instr,       ei);
         chk("pc",       i, id_pc,          tbl[i].e_pc);
         chk("pcplus4",  i, id_pcplus4,     tbl[i].e_pc + 32'd4);
         chk("op",       i, 32'(op),        32'(ei[6:0]));
         chk("funct3",   i, 32'(funct3),    32'(ei[14:12]));
         chk("funct7b5", i, 32'(funct7b5),  32'(ei[30]));
      end

      // PC wrap: redirect to the last word, fetch it, PC rolls over to 0
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("wrap_req",   0, 32'(imem_req), 32'h1);
      chk("wrap_addr",  0, imem_addr,     32'hFFFF_FFFC);
      drive(1'b0, 1'b1, 32'h00108093, 1'b0, 1'b0, 32'h0);
      chk("wrap_pc",    1, imem_addr,     32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("wrap_req",   2, 32'(imem_req), 32'h1);
      chk("wrap_addr",  2, imem_addr,     32'h0);
      chk("wrap_idpc",  2, id_pc,         32'hFFFF_FFFC);
      chk("wrap_pc4",   2, id_pcplus4,    32'h0);
      chk("wrap_instr", 2, id_instr,      32'h00108093);

      // Async reset while a fetch is outstanding and the buffer holds data
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("pre_rst_valid", 0, 32'(id_valid), 32'h1);
      chk("pre_rst_req",   0, 32'(imem_req), 32'h0);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs(1);

      // Back-pressure: only FIFO_DEPTH fetches issue, then drain in order
      @(posedge clk); #2 rst_n = 1'b1;
      pend   = 1'b0;
      grants = 0;
      for (int c = 0; c < 10; c++) auto_cycle(1'b0);
      chk("stall_grants", 0, 32'(grants),   32'd2);
      chk("stall_req",    0, 32'(imem_req), 32'h0);
      npop = 0;
      for (int c = 0; c < 40 && npop < 4; c++) begin
         auto_cycle(1'b1);
         if (id_valid) begin
            got_pc[npop] = id_pc;
            got_in[npop] = id_instr;
            npop++;
         end
      end
      chk("drain_count", 0, 32'(npop), 32'd4);
      for (int k = 0; k < npop; k++) begin
         chk("drain_pc",    k, got_pc[k], 32'(k * 4));
         chk("drain_instr", k, got_in[k], instr_of(32'(k * 4)));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
